// File: rtl/pc_ras.sv
// pc_ras: fetch program counter with a circular return-address stack, interrupt redirect and sticky stack-error flags
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   pcEn                           advance enable; low holds PC, stack and flags (clr_err still acts)
//   branch/jump/call/ret/irq       control strobes, priority irq > ret > call > jump > branch
//   clr_err                        clear ras_ovf/ras_unf
//   disp, dSrc                     signed branch displacement, jump/call target
//   pc, pc1                        registered PC, combinational pc + (branch ? sext(disp) : 1)
//   ras_empty, ras_full            stack occupancy
//   ras_ovf, ras_unf               sticky push-while-full / pop-while-empty
module pc_ras #(
    parameter int DATAWIDTH = 16,
    parameter int DISPWIDTH = 8,
    parameter int RAS_DEPTH = 4,
    parameter logic [DATAWIDTH-1:0] RESET_VEC = '0,
    parameter logic [DATAWIDTH-1:0] IRQ_VEC = 16'h0010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pcEn,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 call,
    input  logic                 ret,
    input  logic                 irq,
    input  logic                 clr_err,
    input  logic [DISPWIDTH-1:0] disp,
    input  logic [DATAWIDTH-1:0] dSrc,
    output logic [DATAWIDTH-1:0] pc,
    output logic [DATAWIDTH-1:0] pc1,
    output logic                 ras_empty,
    output logic                 ras_full,
    output logic                 ras_ovf,
    output logic                 ras_unf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [DATAWIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]        top;
    logic [CW-1:0]        cnt;
    logic [DATAWIDTH-1:0] pc_inc, pc_next, push_val;
    logic                 push, pop, new_ovf, new_unf;

    assign pc_inc    = pc + DATAWIDTH'(1);
    assign pc1       = pc + (branch ? DATAWIDTH'($signed(disp)) : DATAWIDTH'(1));
    assign ras_empty = cnt == '0;
    assign ras_full  = cnt == CW'(RAS_DEPTH);

    always_comb begin
        push     = irq | (~ret & call);
        pop      = ~irq & ret;
        push_val = irq ? pc : pc_inc;
        new_ovf  = push & ras_full;
        new_unf  = pop & ras_empty;
        pc_next  = irq ? IRQ_VEC :
                   ret ? (ras_empty ? pc_inc : stack[top]) :
                   (call | jump) ? dSrc : pc1;
    end

    // A push while full lands on top+1, which is the oldest entry, so the overwrite needs no extra logic.
    always_ff @(posedge clk) begin
        if (pcEn && push)
            stack[top + 1'b1] <= push_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_VEC;
            top     <= '0;
            cnt     <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            if (pcEn) begin
                pc <= pc_next;
                if (push) begin
                    top <= top + 1'b1;
                    if (!ras_full)
                        cnt <= cnt + 1'b1;
                end else if (pop && !ras_empty) begin
                    top <= top - 1'b1;
                    cnt <= cnt - 1'b1;
                end
            end
            // A new error in the same cycle as clr_err wins.
            ras_ovf <= (ras_ovf & ~clr_err) | (pcEn & new_ovf);
            ras_unf <= (ras_unf & ~clr_err) | (pcEn & new_unf);
        end
    end
endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: table-driven directed checks for pc_ras plus hand-written reset sequences
module tb_pc_ras;
    logic        clk = 0, rst = 0, pcEn = 0, branch = 0, jump = 0, call = 0, ret = 0, irq = 0, clr_err = 0;
    logic [7:0]  disp = 0;
    logic [15:0] dSrc = 0, pc, pc1;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;
    int          errors = 0, checks = 0;

    pc_ras dut (
        .clk(clk), .rst(rst), .pcEn(pcEn), .branch(branch), .jump(jump), .call(call), .ret(ret),
        .irq(irq), .clr_err(clr_err), .disp(disp), .dSrc(dSrc), .pc(pc), .pc1(pc1),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, br, jp, ca, rt, iq, cl;
        logic [7:0]  disp;
        logic [15:0] dsrc, e_pc1, e_pc;
        logic        e_empty, e_full, e_ovf, e_unf;
    } vec_t;

    vec_t v [31];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        pcEn = t.en; branch = t.br; jump = t.jp; call = t.ca; ret = t.rt; irq = t.iq; clr_err = t.cl;
        disp = t.disp; dSrc = t.dsrc;
    endtask

    initial begin
        //        en br jp ca rt iq cl disp   dsrc      pc1       pc        em fu ov un
        v[0]  = '{1, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0020, 16'h0004, 16'h0020, 1, 0, 0, 0};
        v[1]  = '{1, 1, 0, 0, 0, 0, 0, 8'hF0, 16'h0000, 16'h0010, 16'h0010, 1, 0, 0, 0};
        v[2]  = '{1, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0020, 16'h0011, 16'h0020, 1, 0, 0, 0};
        v[3]  = '{1, 1, 0, 0, 0, 0, 0, 8'h7F, 16'h0000, 16'h009F, 16'h009F, 1, 0, 0, 0};
        v[4]  = '{1, 0, 1, 0, 0, 0, 0, 8'h00, 16'hFFFF, 16'h00A0, 16'hFFFF, 1, 0, 0, 0};
        v[5]  = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0};
        v[6]  = '{1, 1, 0, 0, 0, 0, 0, 8'h80, 16'h0000, 16'hFF80, 16'hFF80, 1, 0, 0, 0};
        v[7]  = '{1, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0005, 16'hFF81, 16'h0005, 1, 0, 0, 0};
        v[8]  = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0100, 16'h0006, 16'h0100, 0, 0, 0, 0};
        v[9]  = '{1, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0101, 16'h0006, 1, 0, 0, 0};
        v[10] = '{1, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0010, 16'h0007, 16'h0010, 1, 0, 0, 0};
        v[11] = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0020, 16'h0011, 16'h0020, 0, 0, 0, 0};
        v[12] = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0030, 16'h0021, 16'h0030, 0, 0, 0, 0};
        v[13] = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0040, 16'h0031, 16'h0040, 0, 0, 0, 0};
        v[14] = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0050, 16'h0041, 16'h0050, 0, 1, 0, 0};
        v[15] = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0060, 16'h0051, 16'h0060, 0, 1, 1, 0};
        v[16] = '{1, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0061, 16'h0051, 0, 0, 1, 0};
        v[17] = '{1, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0052, 16'h0041, 0, 0, 1, 0};
        v[18] = '{1, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0042, 16'h0031, 0, 0, 1, 0};
        v[19] = '{1, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0032, 16'h0021, 1, 0, 1, 0};
        v[20] = '{1, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0022, 16'h0022, 1, 0, 1, 1};
        v[21] = '{0, 0, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h0023, 16'h0022, 1, 0, 0, 0};
        v[22] = '{1, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0033, 16'h0023, 16'h0033, 1, 0, 0, 0};
        v[23] = '{1, 0, 1, 1, 0, 1, 0, 8'h00, 16'h0200, 16'h0034, 16'h0010, 0, 0, 0, 0};
        v[24] = '{1, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0011, 16'h0033, 1, 0, 0, 0};
        v[25] = '{1, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0034, 16'h0034, 1, 0, 0, 1};
        v[26] = '{1, 0, 0, 0, 1, 0, 1, 8'h00, 16'h0000, 16'h0035, 16'h0035, 1, 0, 0, 1};
        v[27] = '{1, 0, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h0036, 16'h0036, 1, 0, 0, 0};
        v[28] = '{0, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0100, 16'h0037, 16'h0036, 1, 0, 0, 0};
        v[29] = '{1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0100, 16'h0037, 16'h0100, 0, 0, 0, 0};
        v[30] = '{1, 0, 1, 1, 1, 0, 0, 8'h00, 16'h0400, 16'h0101, 16'h0037, 1, 0, 0, 0};

        #2;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_empty", 16'(ras_empty), 16'h1);
        chk("reset_full", 16'(ras_full), 16'h0);
        chk("reset_flags", {14'h0, ras_ovf, ras_unf}, 16'h0);

        @(negedge clk);
        rst = 1; pcEn = 1;
        #1 chk("run_pc0", pc, 16'h0000);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("run_pc%0d", i), pc, 16'(i));
        end
        @(negedge clk) pcEn = 0;
        repeat (2) @(posedge clk);
        #1 chk("hold_pc", pc, 16'h0003);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            drive(v[i]);
            #1 chk($sformatf("v%0d_pc1", i), pc1, v[i].e_pc1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_pc", i), pc, v[i].e_pc);
            chk($sformatf("v%0d_flags", i), {12'h0, ras_empty, ras_full, ras_ovf, ras_unf},
                {12'h0, v[i].e_empty, v[i].e_full, v[i].e_ovf, v[i].e_unf});
        end

        @(negedge clk);
        pcEn = 1; branch = 0; jump = 0; call = 0; irq = 0; clr_err = 0; ret = 1;
        @(negedge clk) ret = 0; call = 1; dSrc = 16'h0100;
        @(negedge clk) dSrc = 16'h0200;
        @(posedge clk); #1;
        chk("pre_rst_pc", pc, 16'h0200);
        chk("pre_rst_flags", {12'h0, ras_empty, ras_full, ras_ovf, ras_unf}, 16'h0001);
        #2 rst = 0;
        #1;
        chk("async_rst_pc", pc, 16'h0000);
        chk("async_rst_flags", {12'h0, ras_empty, ras_full, ras_ovf, ras_unf}, 16'h0008);
        @(negedge clk) rst = 1; call = 0; ret = 1;
        @(posedge clk); #1;
        chk("post_rst_pop_pc", pc, 16'h0001);
        chk("post_rst_pop_unf", 16'(ras_unf), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
